// File: rtl/ice_reset_pkg.sv
// ice_reset_pkg: shared state encodings and cause-flag bit indices for the ICE reset controller.
package ice_reset_pkg;
  typedef enum logic [1:0] {
    P_ACT  = 2'd0,
    P_WAIT = 2'd1,
    P_REL  = 2'd2
  } poc_state_e;
  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_HOLD = 2'd1,
    F_DONE = 2'd2,
    F_WAIT = 2'd3
  } frst_state_e;
  localparam int RESF_TERM = 0;
  localparam int RESF_POC  = 1;
  localparam int RESF_ICE  = 2;
endpackage

// File: rtl/ice_rst_filter.sv
// ice_rst_filter: two-flop synchroniser plus stable-count noise filter for an active-low reset pin.
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset
//   i_raw   - raw asynchronous input
//   o_filt  - filtered level, follows the input after FILT_CYC stable differing samples
//   o_fall  - high in the cycle whose edge takes o_filt from 1 to 0
module ice_rst_filter #(
  parameter int FILT_CYC = 4,
  parameter int CNT_W    = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_filt,
  output logic o_fall
);
  logic r_s1, r_s2, r_filt, w_diff, w_flip;
  logic [CNT_W-1:0] r_cnt;
  assign w_diff = r_s2 != r_filt;
  assign w_flip = w_diff && (r_cnt == CNT_W'(FILT_CYC - 1));
  assign o_filt = r_filt;
  assign o_fall = w_flip & r_filt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_cnt  <= (w_diff && !w_flip) ? r_cnt + CNT_W'(1) : '0;
      r_filt <= w_flip ? r_s2 : r_filt;
    end
  end
endmodule

// File: rtl/ice_reset_ctl.sv
// ice_reset_ctl: ICE reset controller driving TERRESB/POCRESB into the ICE reset buffer stage.
//   CLK      - ICE system clock
//   RESB     - asynchronous active-low reset
//   RSTPIN_N - raw external reset pin (synchronised + noise filtered)
//   POCDET_N - raw power-on detector, 0 = power not good (synchronised)
//   FRST_REQ - debugger forced-reset request level
//   FRST_ACK - one-cycle pulse when a forced reset completes
//   RESF_CLR - pulse clearing the TERM and ICE cause flags (POC only while released)
//   TERRESB  - filtered terminal reset, active low
//   POCRESB  - power-on-clear reset, active low
//   RESF     - sticky cause flags {ICE, POC, TERM}
// Define ICE_RSTCTL_FRST_EN to build the debugger forced-reset sequencer.
module ice_reset_ctl
  import ice_reset_pkg::*;
#(
  parameter int FILT_CYC = 4,
  parameter int POC_DLY  = 64,
  parameter int FRST_CYC = 16,
  parameter int CNT_W    = 16
) (
  input  logic       CLK,
  input  logic       RESB,
  input  logic       RSTPIN_N,
  input  logic       POCDET_N,
  input  logic       FRST_REQ,
  output logic       FRST_ACK,
  input  logic       RESF_CLR,
  output logic       TERRESB,
  output logic       POCRESB,
  output logic [2:0] RESF
);
  logic w_pin_filt, w_pin_fall, r_poc_s1, r_poc_s2, r_pocresb, r_terresb;
  logic w_hold, w_hold_entry, w_p_entry, w_rel_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0] r_resf;
  poc_state_e r_pstate, w_pnext;
  ice_rst_filter #(.FILT_CYC(FILT_CYC), .CNT_W(CNT_W)) u_pin_filt (
    .i_clk  (CLK),
    .i_rst_n(RESB),
    .i_raw  (RSTPIN_N),
    .o_filt (w_pin_filt),
    .o_fall (w_pin_fall)
  );
  // Any loss of power sends the POC FSM back to P_ACT; otherwise count down to release.
  always_comb begin
    w_pnext = !r_poc_s2 ? P_ACT :
              (r_pstate == P_ACT) ? ((POC_DLY == 1) ? P_REL : P_WAIT) :
              (r_pstate == P_WAIT && r_cnt != CNT_W'(1)) ? P_WAIT : P_REL;
  end
  assign w_rel_next = w_pnext == P_REL;
  assign w_p_entry  = (w_pnext == P_ACT) && (r_pstate != P_ACT);
  // The delay counter is shared: the POC wait and the forced hold can never overlap,
  // because a hold only starts and survives while the POC FSM sits in P_REL.
  always_comb begin
    w_cnt_next = r_cnt;
    if (r_pstate == P_ACT) w_cnt_next = CNT_W'(POC_DLY - 1);
    else if (r_pstate == P_WAIT) w_cnt_next = r_cnt - CNT_W'(1);
`ifdef ICE_RSTCTL_FRST_EN
    else if (w_hold_entry) w_cnt_next = CNT_W'(FRST_CYC - 1);
    else if (w_hold) w_cnt_next = r_cnt - CNT_W'(1);
`endif
  end
`ifdef ICE_RSTCTL_FRST_EN
  frst_state_e r_fstate, w_fnext;
  logic r_ack;
  // A POCRESB fall aborts the sequence in the same edge, so no ACK is issued.
  always_comb begin
    w_fnext = r_fstate;
    case (r_fstate)
      F_IDLE:  w_fnext = (FRST_REQ && r_pocresb) ? F_HOLD : F_IDLE;
      F_HOLD:  w_fnext = (r_cnt == '0) ? F_DONE : F_HOLD;
      F_DONE:  w_fnext = F_WAIT;
      default: w_fnext = FRST_REQ ? F_WAIT : F_IDLE;
    endcase
    if (!w_rel_next) w_fnext = F_IDLE;
  end
  assign w_hold       = r_fstate == F_HOLD;
  assign w_hold_entry = (r_fstate == F_IDLE) && (w_fnext == F_HOLD);
  assign FRST_ACK     = r_ack;
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      r_fstate <= F_IDLE;
      r_ack    <= 1'b0;
    end else begin
      r_fstate <= w_fnext;
      r_ack    <= w_fnext == F_DONE;
    end
  end
`else
  logic w_unused;
  assign w_unused     = FRST_REQ ^ (FRST_CYC > 255);
  assign w_hold       = 1'b0;
  assign w_hold_entry = 1'b0;
  assign FRST_ACK     = 1'b0;
`endif
  assign TERRESB = r_terresb;
  assign POCRESB = r_pocresb;
  assign RESF    = r_resf;
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      r_poc_s1  <= 1'b0;
      r_poc_s2  <= 1'b0;
      r_pstate  <= P_ACT;
      r_pocresb <= 1'b0;
      r_terresb <= 1'b0;
      r_cnt     <= '0;
      r_resf    <= 3'b010;
    end else begin
      r_poc_s1  <= POCDET_N;
      r_poc_s2  <= r_poc_s1;
      r_pstate  <= w_pnext;
      r_pocresb <= w_rel_next;
      r_terresb <= w_pin_filt & ~w_hold;
      r_cnt     <= w_cnt_next;
      // Priority: POC entry clears, then a new cause sets, then software clear.
      r_resf[RESF_TERM] <= w_p_entry ? 1'b0 : w_pin_fall ? 1'b1 : RESF_CLR ? 1'b0 : r_resf[RESF_TERM];
      r_resf[RESF_POC]  <= (w_pnext == P_ACT) | (r_resf[RESF_POC] & ~(RESF_CLR & r_pocresb));
      r_resf[RESF_ICE]  <= w_p_entry ? 1'b0 : w_hold_entry ? 1'b1 : RESF_CLR ? 1'b0 : r_resf[RESF_ICE];
    end
  end
endmodule

// File: doc/ice_reset_ctl.md
Name: ice_reset_ctl

Overview:
ICE-side reset controller that sits directly upstream of the ICE reset buffer stage and drives its terminal-reset and POC-release inputs.
Conditions the raw external reset pin through a synchroniser and digital noise filter, sequences power-on-clear release with a programmable delay, and merges a debugger-requested forced reset.
Keeps sticky reset-cause flags for the ICE monitor.
Outputs TERRESB and POCRESB, both active low. The downstream buffer derives RTBFG as TERRESB & POCRESB.

Parameters:
FILT_CYC, 4, consecutive stable synchronised samples the pin needs before TERRESB follows it (valid range 1..255).
POC_DLY, 64, cycles from POC detector release to POCRESB=1 (valid range 1..65535).
FRST_CYC, 16, cycles TERRESB is held low for a debugger forced reset (valid range 1..255).
CNT_W, 16, width of the shared delay counter; must hold max(FILT_CYC, POC_DLY, FRST_CYC).

Ports:
CLK  input  1  ICE system clock.
RESB  input  1  Asynchronous active-low reset; one clock, reset asynchronous active-low.
RSTPIN_N  input  1  Raw external reset pin, asynchronous, active low.
POCDET_N  input  1  Raw power-on detector, asynchronous; 0 = power not good.
FRST_REQ  input  1  Debugger forced-reset request, level; sampled when the controller is idle.
FRST_ACK  output  1  One-cycle pulse when a forced reset completes.
RESF_CLR  input  1  One-cycle pulse; clears the TERM and ICE cause flags.
TERRESB  output  1  Filtered terminal reset, active low.
POCRESB  output  1  POC reset, active low.
RESF  output  3  Sticky cause flags: bit0 TERM, bit1 POC, bit2 ICE.

Behaviour:
- Reset (RESB=0) values: TERRESB=0, POCRESB=0, FRST_ACK=0, RESF=3'b010. All synchroniser flops = 0. POC FSM = P_ACT. Filter counter = 0.
- Synchronisers: RSTPIN_N and POCDET_N each pass through two flops; pin_s and poc_s are the synchronised values. Raw-to-sync latency is 2 cycles.
- Noise filter:
  - Counter increments while pin_s != filt_q and clears when they are equal.
  - When the counter reaches FILT_CYC-1 while still differing, filt_q <= pin_s and the counter clears.
  - A glitch shorter than FILT_CYC samples never changes filt_q.
  - filt_q resets to 0.
- POC FSM:
  - P_ACT: POCRESB=0. When poc_s=1, load counter and go to P_WAIT.
  - P_WAIT: POCRESB=0; counter decrements. If poc_s=0, return to P_ACT (the count restarts on the next release). Go to P_REL on the cycle after POC_DLY counts, so POCRESB rises exactly POC_DLY cycles after poc_s rises.
  - P_REL: POCRESB=1. If poc_s=0, go to P_ACT and drive POCRESB=0 on the next clock edge.
- Forced-reset FSM:
  - F_IDLE: if FRST_REQ=1 and POCRESB=1, go to F_HOLD.
  - F_HOLD: force TERRESB low for FRST_CYC cycles, then go to F_DONE.
  - F_DONE: pulse FRST_ACK for 1 cycle, then go to F_WAIT.
  - F_WAIT: wait for FRST_REQ=0 before returning to F_IDLE.
  - If POCRESB falls in any state, return to F_IDLE with no ACK.
- Output: TERRESB = registered (filt_q & ~(fstate==F_HOLD)). This gives 1 cycle of output latency after the filter or FSM changes.
- RESF set/clear rules:
  - bit0 set on a filt_q 1->0 edge.
  - bit2 set on entry to F_HOLD.
  - bit1 set while in P_ACT.
  - A P_ACT entry clears bit0 and bit2; the POC cause dominates.
  - RESF_CLR clears bits 0 and 2 only. If a set and RESF_CLR occur in the same cycle, set wins.
  - Bit1 is cleared only by RESF_CLR while in P_REL.
- Pin activity during P_ACT is still filtered. TERRESB may rise before POCRESB; the downstream AND covers this.

Optional Feature:
ICE_RSTCTL_FRST_EN:
- Defined: forced-reset FSM, FRST_ACK and RESF[2] are implemented as above.
- Undefined: FRST_REQ is ignored, FRST_ACK is tied 0, RESF[2] reads 0, TERRESB = registered filt_q, and no F-state flops are built.

Decomposition:
- Package ice_reset_pkg: POC state enum (P_ACT, P_WAIT, P_REL), forced-reset state enum (F_IDLE, F_HOLD, F_DONE, F_WAIT), RESF bit-index constants (RESF_TERM=0, RESF_POC=1, RESF_ICE=2).
- One natural sub-module, ice_rst_filter: two-flop synchroniser plus stable-count filter. It is instantiated for the pin only; POCDET_N uses a bare synchroniser.

Test Plan:
- Power-up: RESB deassert, POCDET_N=1 at cycle 0, RSTPIN_N=1 -> POCRESB rises at cycle 2+64, TERRESB=1 by cycle 2+4+1, RESF=3'b010.
- Glitch: RSTPIN_N low for 3 clocks (FILT_CYC=4) -> TERRESB stays 1, RESF[0] stays 0. Low for 8 clocks -> TERRESB=0 starting 2+4+1 cycles after the fall, RESF[0]=1.
- POC dropout mid-wait: POCDET_N falls at count 30 of 64, rises again 10 cycles later -> POCRESB stays 0 until a full 64 cycles after the second rise.
- Forced reset (macro defined): FRST_REQ=1 while idle -> TERRESB low for exactly 16 cycles, one FRST_ACK pulse, RESF[2]=1, no retrigger until FRST_REQ=0.
- Clear race: RESF_CLR in the same cycle as a filtered pin fall -> RESF[0]=1. POCDET_N=0 during F_HOLD -> F_IDLE with no ACK, RESF=3'b010.
- Macro undefined: FRST_REQ=1 for 100 cycles -> TERRESB unaffected, FRST_ACK=0, RESF[2]=0.
